// File: rtl/npu_mpram.sv
// npu_mpram -- NPU scratch memory: one byte-strobed write port, NUM_RPORTS
// registered read ports, and a sequential clear engine in place of an array reset.
//
// The storage array carries no reset so it can map onto block RAM. Zeroing is
// done by sweeping one word per cycle. The sweep runs after reset release
// (INIT_CLEAR=1) or when clr_i is pulsed.
//
// Optional feature macro: NPU_MPRAM_BYPASS_EN
//   defined   : write-first. A read that collides with a write to the same
//               address returns the merged word.
//   undefined : read-first. A colliding read returns the old contents, and no
//               forwarding logic is built.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   wen_i           write request
//   waddr_i         write address
//   wdata_i         write data
//   wstrb_i         byte enables (bit k covers wdata_i[8k+7:8k])
//   ren_i           per-port read request
//   raddr_i         packed read addresses; port p uses [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata_o         packed registered read data; holds its value when not reading
//   rvalid_o        per-port read-data valid
//   clr_i           start-clear pulse (ignored while a sweep runs)
//   busy_o          clear sweep in progress
//   clr_done_o      one-cycle pulse after the last word is cleared
//   wdrop_o         one-cycle pulse when a write was rejected
module npu_mpram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int NUM_RPORTS = 2,
  parameter int INIT_CLEAR = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen_i,
  input  logic [ADDR_WIDTH-1:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  input  logic [DATA_WIDTH/8-1:0]          wstrb_i,
  input  logic [NUM_RPORTS-1:0]            ren_i,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RPORTS-1:0]            rvalid_o,
  input  logic                             clr_i,
  output logic                             busy_o,
  output logic                             clr_done_o,
  output logic                             wdrop_o
);

  localparam int                  NB     = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           clr_cnt_q, clr_cnt_d;
  logic                            init_pend_q, init_pend_d;
  logic                            clr_done_q, clr_done_d;
  logic                            wdrop_q, wdrop_d;
  logic [NUM_RPORTS-1:0]           rvalid_q, rvalid_d;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Single physical write port, shared between the user path and the sweep.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;

  logic                  wr_in_range;
  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rd_word;

`ifdef NPU_MPRAM_BYPASS_EN
  logic wr_hit;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

  assign wr_hit = (state_q == IDLE) && wen_i && wr_in_range;
`endif

  assign wr_in_range = {1'b0, waddr_i} < DEPTH_W;

  // Control: sweep FSM, write arbitration and drop detection.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_pend_d = init_pend_q;
    clr_done_d  = 1'b0;
    wdrop_d     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = waddr_i;
    mem_wdata   = wdata_i;
    mem_be      = wstrb_i;
    case (state_q)
      IDLE: begin
        // A user write in the same cycle as clr_i still lands; the sweep
        // that starts next cycle overwrites it.
        if (wen_i && wr_in_range) begin
          mem_we = 1'b1;
        end else if (wen_i && (|wstrb_i)) begin
          wdrop_d = 1'b1;
        end
        if (clr_i || init_pend_q) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          init_pend_d = 1'b0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = '0;
        mem_be    = '1;
        wdrop_d   = wen_i && (|wstrb_i);
        if (clr_cnt_q == LAST) begin
          state_d    = IDLE;
          clr_cnt_d  = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read ports: zero while sweeping or out of range, otherwise the stored word.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ren_i;
    ra       = '0;
    rd_word  = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      ra      = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      rd_word = '0;
      if ((state_q == IDLE) && ({1'b0, ra} < DEPTH_W)) begin
        rd_word = mem[ra];
`ifdef NPU_MPRAM_BYPASS_EN
        if (wr_hit && (waddr_i == ra)) rd_word = merge_bytes(rd_word, wdata_i, wstrb_i);
`endif
      end
      if (ren_i[p]) rdata_d[p*DATA_WIDTH +: DATA_WIDTH] = rd_word;
    end
  end

  // Storage array: no reset so it stays RAM-inferable.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_cnt_q   <= '0;
      init_pend_q <= (INIT_CLEAR != 0);
      clr_done_q  <= 1'b0;
      wdrop_q     <= 1'b0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_pend_q <= init_pend_d;
      clr_done_q  <= clr_done_d;
      wdrop_q     <= wdrop_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rdata_o    = rdata_q;
  assign rvalid_o   = rvalid_q;
  assign busy_o     = (state_q == CLEAR);
  assign clr_done_o = clr_done_q;
  assign wdrop_o    = wdrop_q;

endmodule
